// File: rtl/knn_load_ctrl_if.sv
// CPU write-bus handshake into the KNN load sequencer.
// The master drives valid/wstrb and the loader answers with ready.
interface knn_load_ctrl_if;
  logic valid;
  logic wstrb;
  logic ready;

  modport master (output valid, output wstrb, input  ready);
  modport slave  (input  valid, input  wstrb, output ready);
endinterface

// File: rtl/knn_load_ctrl.sv
// KNN input-path load sequencer: groups accepted CPU writes into items, pulses per item,
// and parks in FULL after a batch until the compute datapath consumes it.
module knn_load_ctrl #(
  parameter  int WORDS_PER_ITEM = 2,
  parameter  int N_ITEMS        = 8,
  localparam int WORD_W = (WORDS_PER_ITEM > 1) ? $clog2(WORDS_PER_ITEM) : 1,
  localparam int ITEM_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic                consume,
  knn_load_ctrl_if.slave      bus,
  output logic [WORD_W-1:0]   word_idx,
  output logic [ITEM_W-1:0]   item_idx,
  output logic                data_loaded,
  output logic [ITEM_W-1:0]   done_idx,
  output logic                all_loaded,
  output logic                overflow
);

  typedef enum logic {S_LOAD = 1'b0, S_FULL = 1'b1} state_e;

  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_ITEM - 1);
  localparam logic [ITEM_W-1:0] ITEM_LAST = ITEM_W'(N_ITEMS - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [ITEM_W-1:0]   item_q, item_d;
  logic                loaded_q, loaded_d;
  logic [ITEM_W-1:0]   done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD;
      word_q   <= '0;
      item_q   <= '0;
      loaded_q <= 1'b0;
      done_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      item_q   <= item_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // A write is any valid with a strobe; reads (valid without wstrb) never count or flag.
  assign wr = bus.valid & bus.wstrb;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    item_d   = item_q;
    loaded_d = 1'b0;
    done_d   = done_q;
    ovf_d    = ovf_q;
    if (clear) begin
      state_d = S_LOAD;
      word_d  = '0;
      item_d  = '0;
      done_d  = '0;
      ovf_d   = 1'b0;
    end else if (enable) begin
      unique case (state_q)
        S_LOAD: begin
          if (wr) begin
            if (word_q == WORD_LAST) begin
              word_d   = '0;
              loaded_d = 1'b1;
              done_d   = item_q;
              if (item_q == ITEM_LAST) begin
                item_d  = '0;
                state_d = S_FULL;
              end else begin
                item_d = item_q + 1'b1;
              end
            end else begin
              word_d = word_q + 1'b1;
            end
          end
        end
        S_FULL: begin
          // Writes here are dropped but remembered; consume still releases the batch.
          if (wr)      ovf_d   = 1'b1;
          if (consume) state_d = S_LOAD;
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_comb begin
    bus.ready   = (state_q == S_LOAD);
    all_loaded  = (state_q == S_FULL);
    data_loaded = loaded_q & enable;
    word_idx    = word_q;
    item_idx    = item_q;
    done_idx    = done_q;
    overflow    = ovf_q;
  end

endmodule

// File: tb/tb_knn_load_ctrl.sv
// Directed bench: default-parameter loader plus a WORDS_PER_ITEM=3, N_ITEMS=5 instance.
module tb_knn_load_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0, enable = 1'b1, clear = 1'b0, consume = 1'b0;
  logic valid = 1'b0, wstrb = 1'b0;
  int   n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  knn_load_ctrl_if bus_a ();
  knn_load_ctrl_if bus_b ();
  assign bus_a.valid = valid;
  assign bus_a.wstrb = wstrb;
  assign bus_b.valid = valid;
  assign bus_b.wstrb = wstrb;

  logic [0:0] word_a;
  logic [2:0] item_a, done_a;
  logic       dl_a, all_a, ovf_a;
  logic [1:0] word_b;
  logic [2:0] item_b, done_b;
  logic       dl_b, all_b, ovf_b;

  knn_load_ctrl u_a (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .consume(consume), .bus(bus_a),
    .word_idx(word_a), .item_idx(item_a), .data_loaded(dl_a), .done_idx(done_a),
    .all_loaded(all_a), .overflow(ovf_a)
  );

  knn_load_ctrl #(.WORDS_PER_ITEM(3), .N_ITEMS(5)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .consume(consume), .bus(bus_b),
    .word_idx(word_b), .item_idx(item_b), .data_loaded(dl_b), .done_idx(done_b),
    .all_loaded(all_b), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0; wstrb = 1'b0; consume = 1'b0; clear = 1'b0; enable = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_a();
    valid = 1'b1; wstrb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("bb_pulse", dl_a, i % 2);
      if (i % 2 == 1) chk("bb_done", done_a, i / 2);
    end
    valid = 1'b0; wstrb = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_ready", bus_a.ready, 1);
    chk("rst_word", word_a, 0);
    chk("rst_item", item_a, 0);
    chk("rst_dl", dl_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_all", all_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_ready_b", bus_b.ready, 1);

    // two writes -> one pulse one cycle after the second
    valid = 1'b1; wstrb = 1'b1;
    tick();
    chk("w1_word", word_a, 1);
    chk("w1_dl", dl_a, 0);
    tick();
    valid = 1'b0; wstrb = 1'b0;
    chk("w2_dl", dl_a, 1);
    chk("w2_done", done_a, 0);
    chk("w2_item", item_a, 1);
    chk("w2_word", word_a, 0);
    tick();
    chk("w2_dl_end", dl_a, 0);

    // consume in LOAD is ignored
    consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("cons_load_item", item_a, 1);
    chk("cons_load_ready", bus_a.ready, 1);

    // full batch, overflow, consume
    do_reset();
    fill_a();
    chk("full_all", all_a, 1);
    chk("full_ready", bus_a.ready, 0);
    chk("full_item", item_a, 0);
    valid = 1'b1; wstrb = 1'b1;
    tick();
    valid = 1'b0; wstrb = 1'b0;
    chk("ovf_set", ovf_a, 1);
    chk("ovf_word", word_a, 0);
    chk("ovf_item", item_a, 0);
    chk("ovf_dl", dl_a, 0);
    chk("ovf_all", all_a, 1);
    consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("rel_ready", bus_a.ready, 1);
    chk("rel_item", item_a, 0);
    chk("rel_all", all_a, 0);
    chk("rel_ovf_sticky", ovf_a, 1);

    // enable low freezes; reads never count
    do_reset();
    enable = 1'b0; valid = 1'b1; wstrb = 1'b1;
    tick();
    tick();
    chk("en0_word", word_a, 0);
    chk("en0_dl", dl_a, 0);
    enable = 1'b1; wstrb = 1'b0;
    tick();
    tick();
    chk("rd_word", word_a, 0);
    chk("rd_ovf", ovf_a, 0);
    wstrb = 1'b1;
    tick();
    valid = 1'b0; wstrb = 1'b0;
    chk("en1_word", word_a, 1);

    // write and consume together in FULL
    do_reset();
    fill_a();
    valid = 1'b1; wstrb = 1'b1; consume = 1'b1;
    tick();
    valid = 1'b0; wstrb = 1'b0; consume = 1'b0;
    chk("wc_ready", bus_a.ready, 1);
    chk("wc_ovf", ovf_a, 1);
    chk("wc_word", word_a, 0);
    chk("wc_item", item_a, 0);

    // clear drops overflow and returns to LOAD
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovf", ovf_a, 0);

    // 3x5 instance: partial item cleared, then a full item
    do_reset();
    valid = 1'b1; wstrb = 1'b1;
    tick();
    chk("b_w1_word", word_b, 1);
    valid = 1'b0; wstrb = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("b_clr_word", word_b, 0);
    chk("b_clr_dl", dl_b, 0);
    valid = 1'b1; wstrb = 1'b1;
    tick();
    chk("b_w1_dl", dl_b, 0);
    tick();
    chk("b_w2_word", word_b, 2);
    chk("b_w2_dl", dl_b, 0);
    tick();
    valid = 1'b0; wstrb = 1'b0;
    chk("b_w3_dl", dl_b, 1);
    chk("b_w3_done", done_b, 0);
    chk("b_w3_item", item_b, 1);
    chk("b_w3_word", word_b, 0);
    chk("b_ovf", ovf_b, 0);
    tick();
    chk("b_dl_end", dl_b, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
